// File: rtl/period_meter.sv
// Period / high-time meter for an asynchronous square wave, measured in clk_in cycles.
// Results are held under a valid/ack handshake; overrun and timeout are sticky status flags.
module period_meter #(
  parameter int W       = 24,
  parameter int TIMEOUT = 10_000_000
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         sig_in,
  input  logic         enable,
  input  logic         ack,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         overrun,
  output logic         timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARM     = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;

  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT - 1);

  logic [1:0]   state;
  logic         s1, s2, s3;
  logic [W-1:0] cnt;
  logic [W-1:0] hi_latch;
  logic         rise, fall, at_limit, publish;

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign at_limit = (cnt == CNT_LAST);
  assign publish  = (state == MEASURE) && rise;

  // NOTE: non-blocking assignments make every flop sample its pre-edge input;
  // blocking ones here would collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_latch  <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      timeout   <= 1'b0;
    end else if (!enable) begin
      // Disabling abandons any partial interval but keeps the last published result.
      state   <= IDLE;
      cnt     <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          state <= ARM;
        end
        ARM: begin
          if (rise) begin
            cnt     <= W'(1);
            timeout <= 1'b0;
            state   <= MEASURE;
          end else if (at_limit) begin
            cnt     <= '0;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            period    <= cnt;
            high_time <= hi_latch;
            cnt       <= W'(1);
          end else begin
            if (fall) hi_latch <= cnt;
            if (at_limit) begin
              cnt     <= '0;
              timeout <= 1'b1;
              state   <= ARM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase

      // A result landing together with ack counts as consumed-and-replaced, not lost.
      if (publish) begin
        valid <= 1'b1;
        if (valid && !ack) overrun <= 1'b1;
      end else if (valid && ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: timeout, overrun, ack handshake, collision, enable drop, async reset.
`timescale 1ns/1ps
module tb_period_meter;

  localparam int W       = 24;
  localparam int TIMEOUT = 100;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         sig_in;
  logic         enable;
  logic         ack;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         overrun;
  logic         timeout;

  int errors = 0;
  int checks = 0;

  logic wave_on = 1'b0;
  int   hi_cyc  = 10;
  int   lo_cyc  = 10;
  int   ph      = 0;

  period_meter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .enable    (enable),
    .ack       (ack),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 clk_in = ~clk_in;

  // Square-wave source: hi_cyc sampled-high cycles then lo_cyc low, changing 2ns after each edge.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk_in);
      #2;
      if (wave_on) begin
        sig_in = (ph < hi_cyc);
        ph     = (ph + 1 >= hi_cyc + lo_cyc) ? 0 : ph + 1;
      end else begin
        sig_in = 1'b0;
        ph     = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    ack    = 1'b0;
    tick();
    tick();
    checks++;
    if ({valid, overrun, timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {valid, overrun, timeout});
    end
    checks++;
    if (period !== '0 || high_time !== '0) begin
      errors++;
      $display("FAIL reset_data: got period=%0d high=%0d expected 0/0", period, high_time);
    end
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    bit ok;
    bit early;
    early  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      tick();
      if (timeout !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL timeout_early: got timeout before %0d cycles expected none", TIMEOUT);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_set: got timeout=%b valid=%b expected 1/0", timeout, valid);
    end
    wave_on = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (timeout === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got cleared=%b valid=%b expected 1/0", ok, valid);
    end
    wait_valid(30, ok);
    checks++;
    if (!ok || period !== 24'd20 || high_time !== 24'd10 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL first_result: got valid=%b period=%0d high=%0d ovr=%b expected 1/20/10/0",
               ok, period, high_time, overrun);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (overrun === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || valid !== 1'b1 || period !== 24'd20 || high_time !== 24'd10) begin
      errors++;
      $display("FAIL overrun: got ovr=%b valid=%b period=%0d high=%0d expected 1/1/20/10",
               ok, valid, period, high_time);
    end
    enable = 1'b0;
    tick();
    checks++;
    if ({valid, overrun, timeout} !== 3'b000 || period !== 24'd20 || high_time !== 24'd10) begin
      errors++;
      $display("FAIL disable_clear: got flags=%b period=%0d high=%0d expected 000/20/10",
               {valid, overrun, timeout}, period, high_time);
    end
  endtask

  task automatic test_ack_handshake();
    int results;
    wave_on = 1'b0;
    tick();
    tick();
    hi_cyc  = 3;
    lo_cyc  = 7;
    wave_on = 1'b1;
    enable  = 1'b1;
    results = 0;
    for (int i = 0; i < 80 && results < 3; i++) begin
      tick();
      if (valid === 1'b1) begin
        checks++;
        if (period !== 24'd10 || high_time !== 24'd3 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL ack_result: got period=%0d high=%0d ovr=%b expected 10/3/0",
                   period, high_time, overrun);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
          errors++;
          $display("FAIL ack_clear: got valid=%b expected 0", valid);
        end
        results++;
      end
    end
    checks++;
    if (results != 3) begin
      errors++;
      $display("FAIL ack_count: got %0d results expected 3", results);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    wait_valid(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_wait: got no valid expected valid within 20 cycles");
    end
    for (int i = 0; i < 9; i++) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b1 || overrun !== 1'b0 || period !== 24'd10 || high_time !== 24'd3) begin
      errors++;
      $display("FAIL ack_collision: got valid=%b ovr=%b period=%0d high=%0d expected 1/0/10/3",
               valid, overrun, period, high_time);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL cadence_hold: got valid=%b ovr=%b expected 1/0", valid, overrun);
    end
    tick();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL cadence_overrun: got ovr=%b expected 1", overrun);
    end
  endtask

  task automatic check_two_rises(input string tag);
    bit ok;
    bit early;
    early = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (valid !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL %s_early: got valid within 11 cycles expected none", tag);
    end
    wait_valid(15, ok);
    checks++;
    if (!ok || period !== 24'd10 || high_time !== 24'd3) begin
      errors++;
      $display("FAIL %s_result: got valid=%b period=%0d high=%0d expected 1/10/3",
               tag, ok, period, high_time);
    end
  endtask

  task automatic test_enable_drop();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL drop_pre: got valid=%b expected 1", valid);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0 || overrun !== 1'b0 || period !== 24'd10 || high_time !== 24'd3) begin
      errors++;
      $display("FAIL drop_clear: got valid=%b ovr=%b period=%0d high=%0d expected 0/0/10/3",
               valid, overrun, period, high_time);
    end
    tick();
    tick();
    enable = 1'b1;
    check_two_rises("reenable");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({valid, overrun, timeout} !== 3'b000 || period !== '0 || high_time !== '0) begin
      errors++;
      $display("FAIL async_reset: got flags=%b period=%0d high=%0d expected 000/0/0",
               {valid, overrun, timeout}, period, high_time);
    end
    #2;
    rst_n = 1'b1;
    tick();
    check_two_rises("post_reset");
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_overrun();
    test_ack_handshake();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 SHALL have parameter W, default 24: width of the period, high-time and internal counters.
REQ-002 SHALL have parameter TIMEOUT, default 10_000_000: cycles without a detected rising edge before timeout; must satisfy 2 <= TIMEOUT <= 2^W-1.
REQ-003 SHALL have port clk_in, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port sig_in, input, 1: asynchronous square wave to measure, e.g. a divided clock.
REQ-006 SHALL have port enable, input, 1: measurement enable.
REQ-007 SHALL have port ack, input, 1: consumer acknowledge of the current result.
REQ-008 SHALL have port period, output, W: rise-to-rise interval in clk_in cycles.
REQ-009 SHALL have port high_time, output, W: rise-to-fall interval in clk_in cycles.
REQ-010 SHALL have port valid, output, 1: a result is held, unacknowledged.
REQ-011 SHALL have port overrun, output, 1: an unacknowledged result was overwritten (sticky).
REQ-012 SHALL have port timeout, output, 1: no rising edge seen within TIMEOUT cycles (sticky).

Function
REQ-013 SHALL pass sig_in through a 2-flop synchronizer (s1, s2) plus a history flop s3.
REQ-014 SHALL decode rise = s2 & ~s3 and fall = ~s2 & s3, each one cycle wide; a sig_in transition is detected 2-3 cycles after it occurs.
REQ-015 SHALL implement the states IDLE, ARM and MEASURE.
REQ-016 IDLE: cnt = 0; the block SHALL move to ARM in the cycle after enable is sampled high.
REQ-017 ARM: cnt increments every cycle; on rise the block SHALL set cnt to 1 and move to MEASURE, without publishing a result.
REQ-018 MEASURE, no rise: cnt SHALL increment every cycle; on fall, hi_latch <= cnt.
REQ-019 MEASURE, rise: the block SHALL load period <= cnt and high_time <= hi_latch, set cnt <= 1, and set valid <= 1 in the same edge.
REQ-020 Result: a steady wave with H high cycles and P total cycles SHALL yield period = P and high_time = H.
REQ-021 Handshake: valid SHALL stay high until ack is sampled high while valid = 1, then clear on the next edge.
REQ-022 New result while valid = 1 and ack = 0: period and high_time SHALL be overwritten and overrun <= 1.
REQ-023 New result in the same cycle as ack: valid SHALL stay 1 and overrun SHALL NOT be set.
REQ-024 overrun SHALL clear only when ack is sampled while valid = 1 and no new result arrives in that cycle.
REQ-025 Timeout: in ARM or MEASURE, when cnt = TIMEOUT-1 and no rise occurs, the block SHALL set timeout <= 1, set cnt <= 0, go to ARM, and leave period, high_time and valid unchanged.
REQ-026 timeout SHALL clear on the next rise detected in ARM.
REQ-027 By TIMEOUT <= 2^W-1, cnt SHALL never wrap.
REQ-028 enable sampled low in any state: the block SHALL go to IDLE next edge, with cnt = 0 and valid = 0, overrun and timeout cleared, and period/high_time retained.
REQ-029 enable low SHALL take priority over rise, fall and timeout in the same cycle.
REQ-030 A partial interval (enable drop, timeout, or reset) SHALL never be published.

Reset
REQ-031 rst_n low SHALL immediately force state to IDLE and clear s1, s2, s3, cnt, hi_latch, period, high_time, valid, overrun and timeout, independent of clk_in.
REQ-032 After rst_n deasserts, the first measurement SHALL need two detected rises (ARM first, then MEASURE).
REQ-033 Reset asserted mid-MEASURE SHALL discard the in-progress interval with no spurious valid after release.

Verification
REQ-034 Scenario: W=24, enable=1, ack=0, sig_in 10 high / 10 low -> after the 2nd detected rise, valid=1, period=20, high_time=10; 3rd rise gives the same values with overrun=1.
REQ-035 Scenario: sig_in 3 high / 7 low, ack pulsed each time valid=1 -> period=10, high_time=3, overrun stays 0.
REQ-036 Scenario: TIMEOUT=100, sig_in held 0 after enable -> timeout=1 exactly 100 cycles after entering ARM, valid=0; then a 20-cycle wave -> timeout clears at the 1st rise and valid=1, period=20 after the 2nd.
REQ-037 Scenario: ack asserted in the same cycle a new result lands -> valid remains 1, overrun=0, new period visible.
REQ-038 Scenario: rst_n pulsed low for a half cycle mid-MEASURE -> all outputs 0 asynchronously, and the first valid comes only after two further rises.
REQ-039 Scenario: enable dropped mid-MEASURE with valid=1 -> next edge valid=0, state IDLE, period retained; re-enable requires two rises for a new result.
